// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential 8x8 multiplier between two requesters.
// Capture-to-ack 1 cycle, done-to-response 1 cycle; requests are ignored while busy, and a lost mult_done latches err.
module mult_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic [1:0]  req,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic [1:0]  ack,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        err,
    input  logic        err_clr,
    output logic        mult_start,
    output logic [7:0]  mult_a,
    output logic [7:0]  mult_b,
    input  logic        mult_done,
    input  logic [15:0] mult_product,
    output logic [2:0]  state_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_START = 3'b001,
        S_WAIT  = 3'b010,
        S_RESP  = 3'b011,
        S_ERR   = 3'b100
    } state_t;

    state_t           r_state;
    logic             r_grant_id;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_mult_a;
    logic [7:0]       r_mult_b;
    logic [15:0]      r_rsp_data;
    logic [1:0]       r_ack;
    logic [1:0]       r_rsp_valid;
    logic             r_mult_start;
    logic             r_busy;
    logic             r_err;
    logic             w_pick;

    // On a tie the requester that was not served last wins.
    assign w_pick = (req == 2'b11) ? ~r_last_grant : req[1];

    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_state      <= S_IDLE;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_rsp_data   <= '0;
            r_ack        <= '0;
            r_rsp_valid  <= '0;
            r_mult_start <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ack        <= '0;
            r_rsp_valid  <= '0;
            r_mult_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        r_grant_id   <= w_pick;
                        r_mult_a     <= w_pick ? a1 : a0;
                        r_mult_b     <= w_pick ? b1 : b0;
                        r_ack        <= w_pick ? 2'b10 : 2'b01;
                        r_mult_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mult_done) begin
                        r_rsp_data  <= mult_product;
                        r_rsp_valid <= r_grant_id ? 2'b10 : 2'b01;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_last_grant <= r_grant_id;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                S_ERR: begin
                    if (err_clr) begin
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign busy       = r_busy;
    assign err        = r_err;
    assign mult_start = r_mult_start;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;
    assign state_out  = r_state;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]  ack, rsp_valid;
    logic [15:0] rsp_data;
    logic        busy, err;
    logic        err_clr = 1'b0;
    logic        mult_start;
    logic [7:0]  mult_a, mult_b;
    logic        mult_done = 1'b0;
    logic [15:0] mult_product = '0;
    logic [2:0]  state_out;

    int compared = 0;
    int mismatched = 0;
    int lg = 1;  // model: requester served most recently

    mult_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .reset_a(reset_a), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .err(err), .err_clr(err_clr),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_product(mult_product),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a0 = 8'($urandom); b0 = 8'($urandom);
        a1 = 8'($urandom); b1 = 8'($urandom);
    endtask

    task automatic apply_reset();
        reset_a = 1'b1; req = 2'b00; mult_done = 1'b0; err_clr = 1'b0;
        tick();
        reset_a = 1'b0;
        lg = 1;
    endtask

    // One full transaction: capture, dly WAIT cycles with done on the last, response, back to idle.
    task automatic do_txn(input logic [1:0] r, input logic [1:0] hold, input int dly, input string tag);
        int          win;
        logic [1:0]  eack;
        logic [7:0]  ea, eb;
        logic [15:0] p;
        if (r == 2'b11) win = 1 - lg;
        else if (r == 2'b01) win = 0;
        else win = 1;
        eack = (win == 1) ? 2'b10 : 2'b01;
        ea = (win == 1) ? a1 : a0;
        eb = (win == 1) ? b1 : b0;
        p = 16'(ea) * 16'(eb);
        req = r;
        tick();
        compared++;
        if ({ack, mult_start, busy, state_out, mult_a, mult_b} !== {eack, 1'b1, 1'b1, 3'b001, ea, eb}) begin
            mismatched++;
            $display("FAIL %s start: ack=%b ms=%b busy=%b st=%b a=%0d b=%0d want ack=%b ms=1 busy=1 st=001 a=%0d b=%0d",
                     tag, ack, mult_start, busy, state_out, mult_a, mult_b, eack, ea, eb);
        end
        req = hold;
        rand_ops();
        for (int k = 1; k <= dly; k++) begin
            tick();
            compared++;
            if ({ack, mult_start, rsp_valid, state_out, busy} !== {2'b00, 1'b0, 2'b00, 3'b010, 1'b1}) begin
                mismatched++;
                $display("FAIL %s wait%0d: ack=%b ms=%b rv=%b st=%b busy=%b want ack=00 ms=0 rv=00 st=010 busy=1",
                         tag, k, ack, mult_start, rsp_valid, state_out, busy);
            end
            if (k == dly) begin
                mult_done = 1'b1;
                mult_product = p;
            end
        end
        tick();
        mult_done = 1'b0;
        mult_product = 16'($urandom);
        compared++;
        if ({rsp_valid, rsp_data, state_out, ack, busy} !== {eack, p, 3'b011, 2'b00, 1'b1}) begin
            mismatched++;
            $display("FAIL %s resp: rv=%b data=%0d st=%b ack=%b busy=%b want rv=%b data=%0d st=011 ack=00 busy=1",
                     tag, rsp_valid, rsp_data, state_out, ack, busy, eack, p);
        end
        lg = win;
        tick();
        compared++;
        if ({state_out, busy, rsp_valid, ack, rsp_data, mult_a, mult_b} !== {3'b000, 1'b0, 2'b00, 2'b00, p, ea, eb}) begin
            mismatched++;
            $display("FAIL %s idle: st=%b busy=%b rv=%b ack=%b data=%0d a=%0d b=%0d want st=000 busy=0 rv=00 ack=00 data=%0d a=%0d b=%0d",
                     tag, state_out, busy, rsp_valid, ack, rsp_data, mult_a, mult_b, p, ea, eb);
        end
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        req = 2'b11;
        tick();
        tick();
        compared++;
        if ({state_out, ack, rsp_valid, mult_start, busy, err, rsp_data, mult_a, mult_b} !== '0) begin
            mismatched++;
            $display("FAIL reset: st=%b ack=%b rv=%b ms=%b busy=%b err=%b data=%0d a=%0d b=%0d want all zero",
                     state_out, ack, rsp_valid, mult_start, busy, err, rsp_data, mult_a, mult_b);
        end
        req = 2'b00;
        reset_a = 1'b0;
        lg = 1;
    endtask

    task automatic test_single();
        rand_ops();
        a0 = 8'd12; b0 = 8'd13;
        do_txn(2'b01, 2'b00, 5, "single");
        compared++;
        if (rsp_data !== 16'd156) begin
            mismatched++;
            $display("FAIL single_product: data=%0d want 156", rsp_data);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        rand_ops();
        do_txn(2'b11, 2'b11, 4, "tie_first");
        rand_ops();
        do_txn(2'b11, 2'b11, 2, "tie_second");
        rand_ops();
        do_txn(2'b11, 2'b00, 3, "tie_third");
    endtask

    task automatic test_lockout();
        rand_ops();
        do_txn(2'b01, 2'b10, 6, "lock_req0");
        do_txn(2'b10, 2'b00, 3, "lock_req1");
    endtask

    task automatic test_wait_bounds();
        rand_ops();
        do_txn(2'b01, 2'b00, 1, "dly_min");
        rand_ops();
        do_txn(2'b10, 2'b00, 15, "dly_max");
    endtask

    task automatic test_timeout();
        apply_reset();
        rand_ops();
        req = 2'b01;
        tick();
        req = 2'b00;
        compared++;
        if ({state_out, mult_start} !== {3'b001, 1'b1}) begin
            mismatched++;
            $display("FAIL to_start: st=%b ms=%b want st=001 ms=1", state_out, mult_start);
        end
        for (int k = 1; k <= 15; k++) begin
            tick();
            compared++;
            if ({state_out, err} !== {3'b010, 1'b0}) begin
                mismatched++;
                $display("FAIL to_wait%0d: st=%b err=%b want st=010 err=0", k, state_out, err);
            end
        end
        for (int k = 0; k < 3; k++) begin
            mult_done = (k == 1);
            req = 2'b11;
            tick();
            compared++;
            if ({state_out, err, busy, ack, rsp_valid, mult_start} !== {3'b100, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0}) begin
                mismatched++;
                $display("FAIL to_err%0d: st=%b err=%b busy=%b ack=%b rv=%b ms=%b want st=100 err=1 busy=1 ack=00 rv=00 ms=0",
                         k, state_out, err, busy, ack, rsp_valid, mult_start);
            end
        end
        mult_done = 1'b0;
        req = 2'b00;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        compared++;
        if ({state_out, err, busy} !== {3'b000, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL to_clear: st=%b err=%b busy=%b want st=000 err=0 busy=0", state_out, err, busy);
        end
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        compared++;
        if ({state_out, rsp_valid, busy} !== {3'b000, 2'b00, 1'b0}) begin
            mismatched++;
            $display("FAIL idle_done: st=%b rv=%b busy=%b want st=000 rv=00 busy=0", state_out, rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        rand_ops();
        req = 2'b10;
        tick();
        req = 2'b00;
        tick();
        tick();
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        lg = 1;
        compared++;
        if ({state_out, ack, rsp_valid, mult_start, busy, err, rsp_data, mult_a, mult_b} !== '0) begin
            mismatched++;
            $display("FAIL midreset: st=%b ack=%b rv=%b ms=%b busy=%b err=%b data=%0d a=%0d b=%0d want all zero",
                     state_out, ack, rsp_valid, mult_start, busy, err, rsp_data, mult_a, mult_b);
        end
        mult_done = 1'b1;
        mult_product = 16'hBEEF;
        tick();
        mult_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            compared++;
            if ({state_out, rsp_valid, rsp_data} !== {3'b000, 2'b00, 16'd0}) begin
                mismatched++;
                $display("FAIL midreset_done%0d: st=%b rv=%b data=%0d want st=000 rv=00 data=0",
                         k, state_out, rsp_valid, rsp_data);
            end
        end
        rand_ops();
        do_txn(2'b11, 2'b00, 2, "post_reset_tie");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            rand_ops();
            do_txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), $urandom_range(1, 15), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_lockout();
        test_wait_bounds();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
